hex_result_tx: RTL and testbench



---
 rtl/hex_cal_pkg.sv | 24 ++
 rtl/hex_result_tx_if.sv | 27 ++
 rtl/nibble_to_ascii.sv | 22 ++
 rtl/hex_result_tx.sv | 136 +++++++++++++
 tb/tb_hex_result_tx.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_cal_pkg.sv
// ---------------------------------------------------------------------------
// hex_cal_pkg
// Shared definitions for the UART hex calculator datapath.
//   ASCII_0 / ASCII_A  : base codes for hex digit conversion
//   ASCII_CR / ASCII_LF: line terminator bytes
//   state_t            : 3-bit state encoding of the result transmitter FSM
// ---------------------------------------------------------------------------
package hex_cal_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        DIGIT = 3'd2,
        CR    = 3'd3,
        LF    = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage

// File: rtl/hex_result_tx_if.sv
// ---------------------------------------------------------------------------
// hex_result_tx_if
// Valid/ready byte handshake towards the UART transmitter.
//   tx_valid : producer has a byte on tx_data
//   tx_data  : ASCII byte
//   tx_ready : consumer accepts the byte this cycle
// Modports: master = byte producer, slave = UART TX side.
// ---------------------------------------------------------------------------
interface hex_result_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/nibble_to_ascii.sv
// ---------------------------------------------------------------------------
// nibble_to_ascii
// Combinational hex digit to uppercase ASCII converter.
//   nibble : 4-bit value 0..15
//   ascii  : 8'h30..8'h39 for 0..9, 8'h41..8'h46 for A..F
// ---------------------------------------------------------------------------
module nibble_to_ascii
    import hex_cal_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_result_tx.sv
// ---------------------------------------------------------------------------
// hex_result_tx
// Captures the multiplier product on alu_done, streams it as uppercase ASCII
// hex (MSB nibble first), optionally with leading zeros suppressed and with a
// CR/LF terminator, over a valid/ready byte handshake.
//   clk      : system clock, rising edge
//   n_rst    : asynchronous active-low reset
//   result   : 32-bit product, valid while alu_done=1
//   alu_done : one-cycle capture strobe
//   tx       : byte handshake (master side)
//   busy     : a capture is being transmitted (any state but IDLE)
//   done     : one-cycle pulse after the last byte is accepted
//   drop     : high in a cycle where alu_done arrives while busy
// ---------------------------------------------------------------------------
module hex_result_tx
    import hex_cal_pkg::*;
#(
    parameter bit SUPPRESS_ZEROS = 1'b0,
    parameter bit APPEND_CRLF    = 1'b1
)(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [31:0]            result,
    input  logic                   alu_done,
    hex_result_tx_if.master        tx,
    output logic                   busy,
    output logic                   done,
    output logic                   drop
);

    state_t      state, state_next;
    logic [31:0] shreg, shreg_next;
    logic [2:0]  cnt, cnt_next;
    logic [7:0]  digit_ascii;

    // The digit on air is always the top nibble of the shift register.
    nibble_to_ascii u_nibble_to_ascii (
        .nibble (shreg[31:28]),
        .ascii  (digit_ascii)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            shreg <= 32'h0;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and output decode. Outputs depend only on the registered
    // state and shift register, so tx_data cannot change while a byte is
    // stalled; shreg and cnt only move on a handshake or while skipping.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        cnt_next    = cnt;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        busy        = (state != IDLE);
        done        = 1'b0;
        drop        = alu_done && (state != IDLE);

        case (state)
            IDLE: begin
                if (alu_done) begin
                    shreg_next = result;
                    cnt_next   = 3'd0;
                    // A capture with a nonzero top digit has nothing to skip,
                    // so it goes straight to DIGIT and keeps the k=0 latency.
                    if (SUPPRESS_ZEROS && (result[31:28] == 4'h0)) begin
                        state_next = SKIP;
                    end else begin
                        state_next = DIGIT;
                    end
                end
            end

            SKIP: begin
                // Look one digit ahead so that the last skip cycle already
                // hands over to DIGIT: first byte appears after exactly k
                // skip cycles.
                if ((shreg[31:28] == 4'h0) && (cnt < 3'd7)) begin
                    shreg_next = shreg << 4;
                    cnt_next   = cnt + 3'd1;
                    if ((shreg[27:24] != 4'h0) || (cnt == 3'd6)) begin
                        state_next = DIGIT;
                    end
                end else begin
                    state_next = DIGIT;
                end
            end

            DIGIT: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = digit_ascii;
                if (tx.tx_ready) begin
                    shreg_next = shreg << 4;
                    cnt_next   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state_next = APPEND_CRLF ? CR : FIN;
                    end
                end
            end

            CR: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = ASCII_CR;
                if (tx.tx_ready) begin
                    state_next = LF;
                end
            end

            LF: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = ASCII_LF;
                if (tx.tx_ready) begin
                    state_next = FIN;
                end
            end

            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_result_tx.sv
// ---------------------------------------------------------------------------
// tb_hex_result_tx
// Three instances share stimulus: defaults, zero suppression, and no CR/LF.
// Expected byte streams come from a table of literal strings and, for random
// captures, from a string-level model of the formatting rules.
// ---------------------------------------------------------------------------
module tb_hex_result_tx;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] result;
    logic        alu_done;
    logic        tx_ready;

    logic        busy_w [3];
    logic        done_w [3];
    logic        drop_w [3];
    logic        tv     [3];
    logic [7:0]  td     [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hex_result_tx_if if_def ();
    hex_result_tx_if if_sup ();
    hex_result_tx_if if_nocr ();

    assign if_def.tx_ready  = tx_ready;
    assign if_sup.tx_ready  = tx_ready;
    assign if_nocr.tx_ready = tx_ready;

    assign tv[0] = if_def.tx_valid;
    assign td[0] = if_def.tx_data;
    assign tv[1] = if_sup.tx_valid;
    assign td[1] = if_sup.tx_data;
    assign tv[2] = if_nocr.tx_valid;
    assign td[2] = if_nocr.tx_data;

    hex_result_tx #(.SUPPRESS_ZEROS(1'b0), .APPEND_CRLF(1'b1)) dut_def (
        .clk(clk), .n_rst(n_rst), .result(result), .alu_done(alu_done),
        .tx(if_def), .busy(busy_w[0]), .done(done_w[0]), .drop(drop_w[0])
    );

    hex_result_tx #(.SUPPRESS_ZEROS(1'b1), .APPEND_CRLF(1'b1)) dut_sup (
        .clk(clk), .n_rst(n_rst), .result(result), .alu_done(alu_done),
        .tx(if_sup), .busy(busy_w[1]), .done(done_w[1]), .drop(drop_w[1])
    );

    hex_result_tx #(.SUPPRESS_ZEROS(1'b0), .APPEND_CRLF(1'b0)) dut_nocr (
        .clk(clk), .n_rst(n_rst), .result(result), .alu_done(alu_done),
        .tx(if_nocr), .busy(busy_w[2]), .done(done_w[2]), .drop(drop_w[2])
    );

    typedef struct {
        logic [31:0] value;
        int          ready_mode;   // 0: always ready, 1: toggle, 2: random
        int          drop_at;      // cycle of a second alu_done, -1 for none
        logic [31:0] drop_value;
        string       def_digits;
        string       sup_digits;
    } vec_t;

    vec_t vecs [7];

    function automatic string dut_name(int d);
        case (d)
            0:       return "def";
            1:       return "sup";
            default: return "nocr";
        endcase
    endfunction

    function automatic string crlf();
        return $sformatf("%c%c", 8'h0D, 8'h0A);
    endfunction

    function automatic string hex_bytes(string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            r = {r, $sformatf("%02h ", s[i])};
        end
        return r;
    endfunction

    // Formatting rules at string level: eight uppercase hex characters, then
    // leading '0' characters removed (keeping at least one) when suppressing.
    function automatic string model_digits(logic [31:0] v, bit sup);
        string s = "";
        int first = 0;
        for (int i = 7; i >= 0; i--) begin
            int n = int'((v >> (4 * i)) & 32'hF);
            s = {s, $sformatf("%c", (n < 10) ? (48 + n) : (55 + n))};
        end
        if (sup) begin
            while (first < 7 && s[first] == "0") first++;
        end
        return s.substr(first, 7);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkStream(input string name, input string actual, input string expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got [%s], expected [%s]", name, hex_bytes(actual), hex_bytes(expected));
        end
    endtask

    // Runs one capture on all three instances, cycle by cycle, and then
    // checks stream contents, latency, stall stability, done/busy timing
    // and drop pulses against the supplied expected digit strings.
    task automatic applyStimulus(input string tag, input logic [31:0] value,
                                 input int ready_mode, input int drop_at,
                                 input logic [31:0] drop_value,
                                 input string def_digits, input string sup_digits);
        string      got [3];
        string      exp [3];
        int         k [3];
        int         first_valid [3];
        int         last_hs [3];
        int         done_cycle [3];
        int         done_count [3];
        int         stall_err [3];
        int         drop_err [3];
        int         busy_err [3];
        bit         prev_valid [3];
        bit         prev_hs [3];
        logic [7:0] prev_data [3];
        bit         finished;

        exp[0] = {def_digits, crlf()};
        exp[1] = {sup_digits, crlf()};
        exp[2] = def_digits;
        k[0] = 0;
        k[1] = 8 - sup_digits.len();
        k[2] = 0;
        for (int d = 0; d < 3; d++) begin
            got[d]         = "";
            first_valid[d] = -1;
            last_hs[d]     = -1;
            done_cycle[d]  = -1;
            done_count[d]  = 0;
            stall_err[d]   = 0;
            drop_err[d]    = 0;
            busy_err[d]    = 0;
            prev_valid[d]  = 1'b0;
            prev_hs[d]     = 1'b0;
            prev_data[d]   = 8'h00;
        end
        finished = 1'b0;

        for (int cycle = 0; cycle < 300 && !finished; cycle++) begin
            @(negedge clk);
            alu_done = (cycle == 0) || (cycle == drop_at);
            if (cycle == 0)            result = value;
            else if (cycle == drop_at) result = drop_value;
            else                       result = $urandom;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = cycle[0];
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            finished = 1'b1;
            for (int d = 0; d < 3; d++) begin
                bit hs;
                if (drop_w[d] !== ((cycle == drop_at) && (cycle > 0))) drop_err[d]++;
                if (prev_valid[d] && !prev_hs[d] && (tv[d] !== 1'b1 || td[d] !== prev_data[d]))
                    stall_err[d]++;
                hs = (tv[d] === 1'b1) && tx_ready;
                if (tv[d] === 1'b1 && first_valid[d] < 0) first_valid[d] = cycle;
                if (hs) begin
                    got[d]     = {got[d], $sformatf("%c", td[d])};
                    last_hs[d] = cycle;
                end
                if (done_w[d] === 1'b1) begin
                    done_count[d]++;
                    done_cycle[d] = cycle;
                end
                if (cycle == 0 && busy_w[d] !== 1'b0) busy_err[d]++;
                if (cycle >= 1 && (done_cycle[d] < 0 || cycle == done_cycle[d]) && busy_w[d] !== 1'b1)
                    busy_err[d]++;
                if (done_cycle[d] >= 0 && cycle == done_cycle[d] + 1 && busy_w[d] !== 1'b0)
                    busy_err[d]++;
                if (done_cycle[d] < 0 || cycle < done_cycle[d] + 1) finished = 1'b0;
                prev_valid[d] = (tv[d] === 1'b1);
                prev_hs[d]    = hs;
                prev_data[d]  = td[d];
            end
        end
        alu_done = 1'b0;

        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s/timeout: got no completion, expected done within 300 cycles", tag);
        end

        for (int d = 0; d < 3; d++) begin
            string n;
            n = $sformatf("%s/%s", tag, dut_name(d));
            checkStream({n, "/stream"}, got[d], exp[d]);
            checkOutput({n, "/first_valid"}, first_valid[d], 1 + k[d]);
            checkOutput({n, "/done_count"}, done_count[d], 1);
            checkOutput({n, "/done_after_last"}, done_cycle[d], last_hs[d] + 1);
            checkOutput({n, "/stall_err"}, stall_err[d], 0);
            checkOutput({n, "/drop_err"}, drop_err[d], 0);
            checkOutput({n, "/busy_err"}, busy_err[d], 0);
            if (ready_mode == 0)
                checkOutput({n, "/last_hs"}, last_hs[d], k[d] + exp[d].len());
        end
    endtask

    task automatic check_idle(input string tag, input bit check_data);
        for (int d = 0; d < 3; d++) begin
            string n;
            n = $sformatf("%s/%s", tag, dut_name(d));
            checkOutput({n, "/tx_valid"}, int'(tv[d]), 0);
            checkOutput({n, "/busy"}, int'(busy_w[d]), 0);
            checkOutput({n, "/done"}, int'(done_w[d]), 0);
            if (check_data) begin
                checkOutput({n, "/tx_data"}, int'(td[d]), 0);
                checkOutput({n, "/drop"}, int'(drop_w[d]), 0);
            end
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        alu_done = 1'b0;
        result   = 32'h0;
        tx_ready = 1'b0;

        vecs[0] = '{32'h0626_0060, 0, -1, 32'h0,         "06260060", "6260060"};
        vecs[1] = '{32'hFFFE_0001, 1, -1, 32'h0,         "FFFE0001", "FFFE0001"};
        vecs[2] = '{32'h0001_E240, 0, -1, 32'h0,         "0001E240", "1E240"};
        vecs[3] = '{32'h0000_0000, 0, -1, 32'h0,         "00000000", "0"};
        vecs[4] = '{32'hDEAD_BEEF, 0, -1, 32'h0,         "DEADBEEF", "DEADBEEF"};
        vecs[5] = '{32'h1234_5678, 0,  3, 32'hABCD_EF01, "12345678", "12345678"};
        vecs[6] = '{32'h0000_000A, 1,  2, 32'h5555_5555, "0000000A", "A"};

        repeat (2) @(negedge clk);
        #1;
        check_idle("reset", 1'b1);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].value, vecs[i].ready_mode,
                          vecs[i].drop_at, vecs[i].drop_value,
                          vecs[i].def_digits, vecs[i].sup_digits);
        end

        // Reset while the default instance is presenting digit index 4 ('C').
        @(negedge clk);
        alu_done = 1'b1;
        result   = 32'h89AB_CDEF;
        tx_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            alu_done = 1'b0;
            result   = 32'h0;
        end
        #1;
        checkOutput("midreset/def/digit4", int'(td[0]), 8'h43);
        n_rst = 1'b0;
        #1;
        check_idle("midreset", 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_idle("postreset", 1'b1);
        end
        applyStimulus("afterreset", 32'h89AB_CDEF, 0, -1, 32'h0, "89ABCDEF", "89ABCDEF");

        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            int mode;
            int dat;
            v    = $urandom >> $urandom_range(0, 31);
            mode = int'($urandom_range(0, 2));
            dat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
            applyStimulus($sformatf("rnd%0d", i), v, mode, dat, $urandom,
                          model_digits(v, 1'b0), model_digits(v, 1'b1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
